// File: rtl/life_pkg.sv
// Shared constants, preset patterns and loader state encoding for the 4x4 life array.
package life_pkg;
  localparam int CELLS    = 16;
  localparam int GRID_DIM = 4;

  // Bit k of each pattern is cell k = GRID_DIM*row + col.
  localparam logic [CELLS-1:0] PAT_BLINKER = 16'h0070;
  localparam logic [CELLS-1:0] PAT_BLOCK   = 16'h0660;
  localparam logic [CELLS-1:0] PAT_GLIDER  = 16'h0742;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/life_pattern_rom.sv
// Combinational preset lookup: 2-bit select to 16-cell pattern, slot 3 user-defined.
module life_pattern_rom
  import life_pkg::*;
#(
  parameter logic [CELLS-1:0] PATTERN3 = 16'h0000
) (
  input  logic [1:0]       sel_i,
  output logic [CELLS-1:0] pattern_o
);
  always_comb begin
    pattern_o = PATTERN3;
    case (sel_i)
      2'd0:    pattern_o = PAT_BLINKER;
      2'd1:    pattern_o = PAT_BLOCK;
      2'd2:    pattern_o = PAT_GLIDER;
      default: pattern_o = PATTERN3;
    endcase
  end
endmodule

// File: rtl/life_pattern_loader.sv
// Writes a preset pattern into the life array one cell per clock, optionally frame-aligned,
// and inhibits the generation step for the whole burst.
module life_pattern_loader
  import life_pkg::*;
#(
  parameter bit               WAIT_FRAME = 1'b1,
  parameter logic [CELLS-1:0] PATTERN3   = 16'h0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [1:0] pattern_sel,
  input  logic       frame,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       val,
  output logic       write_enb,
  output logic       busy,
  output logic       done,
  output logic       run_inhibit
);
  state_e           state_q, state_d;
  logic [3:0]       index_q, index_d;
  logic [CELLS-1:0] pattern_q, pattern_d;
  logic [CELLS-1:0] rom_pattern;

  life_pattern_rom #(.PATTERN3(PATTERN3)) u_rom (
    .sel_i     (pattern_sel),
    .pattern_o (rom_pattern)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      pattern_q <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      pattern_q <= pattern_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    pattern_d = pattern_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          pattern_d = rom_pattern;
          index_d   = '0;
          state_d   = WAIT_FRAME ? ST_SYNC : ST_WRITE;
        end
      end
      ST_SYNC: begin
        if (frame) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // Index wraps to 0 after cell 15, but the FSM leaves WRITE at that point.
        index_d = index_q + 4'd1;
        if (index_q == 4'(CELLS - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Every output decodes registered state only, so no input reaches an output combinationally.
  assign write_enb   = (state_q == ST_WRITE);
  assign row         = index_q[3:2];
  assign col         = index_q[1:0];
  assign val         = write_enb & pattern_q[index_q];
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign run_inhibit = busy;
endmodule
